// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the sync FIFO: pops words, absorbs the one-cycle read latency in a
// 2-entry skid buffer and emits a valid/ready stream. Define STREAM_LAST_EN for PKT_LEN m_last framing.
module fifo_stream_reader #(
   parameter  int WIDTH   = 8,
   parameter  int PKT_LEN = 4,
   localparam int CNT_W   = $clog2(PKT_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic [WIDTH-1:0] fifo_rdata,
   input  logic             fifo_rd_error,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   output logic             busy,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic             inflight_r;
   logic [1:0]       buf_cnt_r;
   logic [WIDTH-1:0] buf0_r;
   logic [WIDTH-1:0] buf1_r;
   logic             err_r;
   logic             pop_s;
   logic             rd_en_s;
   logic             busy_s;
   logic             last_s;
   logic             iss_zero_s;
   logic [1:0]       occ_s;

   if (PKT_LEN < 1 || PKT_LEN > 256 || CNT_W < 1) begin : g_bad_cfg
      $error("fifo_stream_reader: PKT_LEN must be in 1..256");
   end

   assign m_valid    = (buf_cnt_r != 2'd0);
   assign m_data     = buf0_r;
   assign pop_s      = m_valid & m_ready;
   assign occ_s      = buf_cnt_r + {1'b0, inflight_r};
   assign fifo_rd_en = rd_en_s;
   assign busy       = busy_s;
   assign m_last     = last_s;
   assign err        = err_r;

`ifdef STREAM_LAST_EN
   logic [CNT_W-1:0] iss_cnt_r;
   logic [CNT_W-1:0] out_cnt_r;

   assign iss_zero_s = (iss_cnt_r == {CNT_W{1'b0}});

   // Issued-beat and accepted-beat counters, both wrapping at packet length
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         iss_cnt_r <= {CNT_W{1'b0}};
         out_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (rd_en_s) begin
            iss_cnt_r <= (iss_cnt_r == CNT_W'(PKT_LEN - 1)) ? {CNT_W{1'b0}} : iss_cnt_r + CNT_W'(1);
         end
         if (pop_s) begin
            out_cnt_r <= (out_cnt_r == CNT_W'(PKT_LEN - 1)) ? {CNT_W{1'b0}} : out_cnt_r + CNT_W'(1);
         end
      end
   end
`else
   assign iss_zero_s = 1'b1;
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; STOP only retires on a packet boundary with nothing left in the pipe
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (en) state_s = RUN;
            else    state_s = IDLE;
         end
         RUN: begin
            if (!en) state_s = STOP;
            else     state_s = RUN;
         end
         STOP: begin
            if (en)                                                state_s = RUN;
            else if (iss_zero_s && !inflight_r && buf_cnt_r == 2'd0) state_s = IDLE;
            else                                                   state_s = STOP;
         end
         default: state_s = IDLE;
      endcase
   end

   // Output logic: read issue only when the buffer can absorb the word arriving next cycle
   always_comb begin
      rd_en_s = 1'b0;
      busy_s  = (state_r != IDLE) | inflight_r | (buf_cnt_r != 2'd0);
      last_s  = 1'b0;
      if (!fifo_empty &&
          ((state_r == RUN) || (state_r == STOP && !iss_zero_s)) &&
          ((occ_s <= 2'd1) || (occ_s == 2'd2 && pop_s))) begin
         rd_en_s = 1'b1;
      end else begin
         rd_en_s = 1'b0;
      end
`ifdef STREAM_LAST_EN
      if (m_valid && out_cnt_r == CNT_W'(PKT_LEN - 1)) last_s = 1'b1;
      else                                             last_s = 1'b0;
`endif
   end

   // Skid buffer: capture at tail on the cycle after a read, pop from head on acceptance
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight_r <= 1'b0;
         buf_cnt_r  <= 2'd0;
         buf0_r     <= {WIDTH{1'b0}};
         buf1_r     <= {WIDTH{1'b0}};
      end else begin
         inflight_r <= rd_en_s;
         case ({inflight_r, pop_s})
            2'b10: begin
               if (buf_cnt_r == 2'd0) buf0_r <= fifo_rdata;
               else                   buf1_r <= fifo_rdata;
               buf_cnt_r <= buf_cnt_r + 2'd1;
            end
            2'b01: begin
               buf0_r    <= buf1_r;
               buf_cnt_r <= buf_cnt_r - 2'd1;
            end
            2'b11: begin
               if (buf_cnt_r == 2'd2) begin
                  buf0_r <= buf1_r;
                  buf1_r <= fifo_rdata;
               end else begin
                  buf0_r <= fifo_rdata;
               end
            end
            default: begin
               buf_cnt_r <= buf_cnt_r;
            end
         endcase
      end
   end

   // Sticky error: FIFO underflow, or a read issued against an empty FIFO
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_r | fifo_rd_error | (rd_en_s & fifo_empty);
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO model feeds the DUT and a scoreboard checks
// order, framing, hold, occupancy bounds and flags. Follows STREAM_LAST_EN like the design.
module tb_fifo_stream_reader;

   localparam int WIDTH   = 8;
   localparam int PKT_LEN = 4;
`ifdef STREAM_LAST_EN
   localparam bit LAST_EN = 1'b1;
`else
   localparam bit LAST_EN = 1'b0;
`endif

   logic             clk;
   logic             rst;
   logic             en;
   logic             fifo_empty;
   logic             fifo_rd_en;
   logic [WIDTH-1:0] fifo_rdata;
   logic             fifo_rd_error;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
   logic             m_last;
   logic             busy;
   logic             err;

   fifo_stream_reader #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rdata   (fifo_rdata),
      .fifo_rd_error(fifo_rd_error),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last),
      .busy         (busy),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [WIDTH-1:0] fq[$];
   logic [WIDTH-1:0] expq[$];
   int  n_checks = 0;
   int  n_errors = 0;
   int  cyc = 0;
   int  iss_total = 0;
   int  acc_total = 0;
   bit  err_exp = 1'b0;
   bit  exp_no_rd = 1'b0;
   bit  prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;
   bit  last_fetch = 1'b0;
   bit  last_acc = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push(input logic [WIDTH-1:0] w);
      fq.push_back(w);
      expq.push_back(w);
      fifo_empty = 1'b0;
   endtask

   // One clock: check outputs at the falling edge, then update the FIFO model after the rising edge
   task automatic cycle();
      bit exp_last;
      @(negedge clk);
      cyc++;
      last_fetch = fifo_rd_en;
      last_acc   = m_valid & m_ready;
      check("rd_on_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
      check("err", 32'(err), 32'(err_exp));
      if (exp_no_rd) check("rd_idle", 32'(fifo_rd_en), 32'd0);
      if (m_valid) begin
         exp_last = LAST_EN && ((acc_total % PKT_LEN) == PKT_LEN - 1);
         check("last", 32'(m_last), 32'(exp_last));
         if (prev_stall) check("hold_data", 32'(m_data), 32'(prev_data));
         if (m_ready) begin
            if (expq.size() == 0) check("extra_beat", 32'(expq.size()), 32'd1);
            else                  check("data", 32'(m_data), 32'(expq.pop_front()));
            acc_total++;
         end
      end else begin
         check("last_idle", 32'(m_last), 32'd0);
         if (prev_stall) check("hold_valid", 32'(m_valid), 32'd1);
      end
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
      if (last_fetch) iss_total++;
      check("outstanding", 32'((iss_total - acc_total) <= 2), 32'd1);
      @(posedge clk);
      #1;
      if (last_fetch && fq.size() != 0) fifo_rdata = fq.pop_front();
      else                              fifo_rdata = WIDTH'($urandom);
      fifo_empty    = (fq.size() == 0);
      fifo_rd_error = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      en = 1'b0;
      m_ready = 1'b0;
      fifo_rd_error = 1'b0;
      fq.delete();
      expq.delete();
      fifo_empty = 1'b1;
      fifo_rdata = '0;
      iss_total = 0;
      acc_total = 0;
      err_exp = 1'b0;
      exp_no_rd = 1'b0;
      prev_stall = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int n_rd;
      int n_acc;
      int first_acc;
      int last_acc_cyc;
      int stop_exp;

      // Reset values
      rst = 1'b0;
      en = 1'b0;
      m_ready = 1'b0;
      fifo_empty = 1'b1;
      fifo_rdata = '0;
      fifo_rd_error = 1'b0;
      #3;
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      do_reset();

      // Reset mid-stream, then no reads until en is sampled
      for (int i = 0; i < 5; i++) push(WIDTH'(8'hA0 + i));
      en = 1'b1;
      m_ready = 1'b1;
      repeat (4) cycle();
      check("mid_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      check("arst_valid", 32'(m_valid), 32'd0);
      check("arst_data", 32'(m_data), 32'd0);
      check("arst_last", 32'(m_last), 32'd0);
      check("arst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_err", 32'(err), 32'd0);
      do_reset();
      for (int i = 0; i < 5; i++) push(WIDTH'(8'hB0 + i));
      m_ready = 1'b1;
      exp_no_rd = 1'b1;
      repeat (3) cycle();
      exp_no_rd = 1'b0;
      en = 1'b1;
      cycle();
      check("first_rd_early", 32'(last_fetch), 32'd0);
      cycle();
      check("first_rd", 32'(last_fetch), 32'd1);
      for (int i = 0; i < 20 && expq.size() != 0; i++) cycle();
      check("rst_drain", 32'(expq.size()), 32'd0);

      // Full-rate drain
      do_reset();
      for (int i = 0; i < 8; i++) push(WIDTH'(8'h10 + i));
      en = 1'b1;
      m_ready = 1'b1;
      n_rd = 0;
      n_acc = 0;
      first_acc = -1;
      last_acc_cyc = -1;
      for (int i = 0; i < 16; i++) begin
         cycle();
         if (last_fetch) n_rd++;
         if (last_acc) begin
            n_acc++;
            if (first_acc < 0) first_acc = cyc;
            last_acc_cyc = cyc;
         end
      end
      check("full_rd_cnt", 32'(n_rd), 32'd8);
      check("full_acc_cnt", 32'(n_acc), 32'd8);
      check("full_consec", 32'(last_acc_cyc - first_acc), 32'd7);

      // Backpressure from the first valid beat
      do_reset();
      for (int i = 0; i < 6; i++) push(WIDTH'(8'h10 + i));
      en = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         m_ready = !(c >= 4);
         cycle();
      end
      check("stall_issue", 32'(iss_total), 32'd2);
      check("stall_head", 32'(m_data), 32'h10);
      m_ready = 1'b1;
      for (int i = 0; i < 30 && expq.size() != 0; i++) cycle();
      check("bp_drain", 32'(expq.size()), 32'd0);

      // Empty boundary: two words, gap, five more
      do_reset();
      push(8'h21);
      push(8'h22);
      en = 1'b1;
      m_ready = 1'b1;
      repeat (5) cycle();
      for (int i = 0; i < 5; i++) push(WIDTH'(8'h30 + i));
      for (int i = 0; i < 30 && expq.size() != 0; i++) cycle();
      check("gap_drain", 32'(expq.size()), 32'd0);

      // Stop after the second issued beat
      do_reset();
      for (int i = 0; i < 10; i++) push(WIDTH'(8'h40 + i));
      en = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 10 && iss_total < 2; i++) cycle();
      check("stop_reach", 32'(iss_total), 32'd2);
      en = 1'b0;
      cycle();
      for (int i = 0; i < 40 && busy; i++) cycle();
      stop_exp = LAST_EN ? PKT_LEN : 3;
      check("stop_busy", 32'(busy), 32'd0);
      check("stop_beats", 32'(acc_total), 32'(stop_exp));
      check("stop_issued", 32'(iss_total), 32'(stop_exp));
      exp_no_rd = 1'b1;
      repeat (5) cycle();
      exp_no_rd = 1'b0;

      // Randomized traffic with random backpressure and enable
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 1) == 0 && fq.size() < 16) push(WIDTH'($urandom));
         m_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) en = ~en;
         cycle();
      end
      en = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 200 && (expq.size() != 0 || busy); i++) begin
         if (expq.size() == 0) en = 1'b0;
         cycle();
      end
      check("rand_drain", 32'(expq.size()), 32'd0);
      check("rand_idle", 32'(busy), 32'd0);

      // Sticky error flag
      fifo_rd_error = 1'b1;
      cycle();
      err_exp = 1'b1;
      repeat (4) cycle();
      do_reset();
      repeat (2) cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
